// File: rtl/ysyx_22050243_clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled free-running mtime behind the core data bus.
// Latency: read data and write acknowledge are registered, one cycle after the request edge.
// Backpressure: none; one request is accepted every cycle and each gets its own response pulse.
module ysyx_22050243_clint #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_w_en,
    input  logic        data_r_en,
    input  logic [7:0]  data_wmask,
    input  logic [63:0] data_addr,
    input  logic [63:0] data_w,
    output logic [63:0] data_r,
    output logic        data_r_valid,
    output logic        data_w_ready,
    output logic        clint_timer_irq_o,
    input  logic        timer_irq_ready_i,
    output logic        msip_o
);

    localparam int unsigned   DW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [63:0]   MSIP_A     = BASE_ADDR;
    localparam logic [63:0]   MTIMECMP_A = BASE_ADDR + 64'h4000;
    localparam logic [63:0]   MTIME_A    = BASE_ADDR + 64'hBFF8;

    typedef enum logic {IDLE, PENDING} irq_state_e;

    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic        cmp_ge, cmp_ge_q;
    logic [63:0] data_r_q, data_r_d;
    logic        data_r_valid_q, data_w_ready_q;
    irq_state_e  state_q, state_d;

    logic [63:0] bmask;
    logic        hit_msip, hit_cmp, hit_time;
    logic        unused_addr_bits;

    // Registers are 8-byte aligned; the low address bits carry no information.
    assign unused_addr_bits = ^data_addr[2:0];

    assign hit_msip = (data_addr[63:3] == MSIP_A[63:3]);
    assign hit_cmp  = (data_addr[63:3] == MTIMECMP_A[63:3]);
    assign hit_time = (data_addr[63:3] == MTIME_A[63:3]);

    // Expand the byte enables into a bit mask for the read-modify-write merge.
    always_comb begin
        bmask = '0;
        for (int i = 0; i < 8; i++) begin
            bmask[i*8 +: 8] = {8{data_wmask[i]}};
        end
    end

    // Read mux samples the registered state, so mtime reads see the pre-increment value.
    always_comb begin
        data_r_d = data_r_q;
        if (data_r_en) begin
            data_r_d = '0;
            if (hit_msip)      data_r_d = {63'd0, msip_q};
            else if (hit_cmp)  data_r_d = mtimecmp_q;
            else if (hit_time) data_r_d = mtime_q;
        end
    end

    // Next-state for the architectural registers; a software write to mtime beats the tick.
    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q;
        div_cnt_d  = div_cnt_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            mtime_d   = mtime_q + 64'd1;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
        if (data_w_en) begin
            if (hit_msip) begin
                msip_d = (msip_q & ~bmask[0]) | (data_w[0] & bmask[0]);
            end
            if (hit_cmp) begin
                mtimecmp_d = (mtimecmp_q & ~bmask) | (data_w & bmask);
            end
            if (hit_time) begin
                mtime_d   = (mtime_q & ~bmask) | (data_w & bmask);
                div_cnt_d = '0;
            end
        end
    end

    assign cmp_ge = (mtime_q >= mtimecmp_q);

    // Register file, prescaler, compare history and response pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip_q         <= 1'b0;
            mtimecmp_q     <= '0;
            mtime_q        <= '0;
            div_cnt_q      <= '0;
            cmp_ge_q       <= 1'b0;
            data_r_q       <= '0;
            data_r_valid_q <= 1'b0;
            data_w_ready_q <= 1'b0;
        end else begin
            msip_q         <= msip_d;
            mtimecmp_q     <= mtimecmp_d;
            mtime_q        <= mtime_d;
            div_cnt_q      <= div_cnt_d;
            cmp_ge_q       <= cmp_ge;
            data_r_q       <= data_r_d;
            data_r_valid_q <= data_r_en;
            data_w_ready_q <= data_w_en;
        end
    end

    // Pending-flag state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Edge-triggered raise on cmp_ge rising; acknowledge always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmp_ge && !cmp_ge_q && !timer_irq_ready_i) state_d = PENDING;
            PENDING: if (timer_irq_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs straight from registers.
    always_comb begin
        clint_timer_irq_o = (state_q == PENDING);
        msip_o            = msip_q;
        data_r            = data_r_q;
        data_r_valid      = data_r_valid_q;
        data_w_ready      = data_w_ready_q;
    end

endmodule

// File: tb/tb_ysyx_22050243_clint.sv
// Directed bench for the CLINT: register-map vector table plus timer, wrap, irq and reset sequences.
// Latency: responses are checked #1 after the edge that samples the request.
// Backpressure: none expected; every request is checked for its own pulse.
module tb_ysyx_22050243_clint;

    localparam logic [63:0] A_MSIP  = 64'h0200_0000;
    localparam logic [63:0] A_CMP   = 64'h0200_4000;
    localparam logic [63:0] A_TIME  = 64'h0200_BFF8;
    localparam logic [63:0] A_UNMAP = 64'h0200_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_w_en, data_r_en;
    logic [7:0]  data_wmask;
    logic [63:0] data_addr, data_w;
    logic        timer_irq_ready_i;

    logic [63:0] data_r;
    logic        data_r_valid, data_w_ready, clint_timer_irq_o, msip_o;
    logic [63:0] d4_data_r;
    logic        d4_data_r_valid, d4_data_w_ready, d4_irq, d4_msip;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ysyx_22050243_clint dut (
        .clk(clk), .rst(rst),
        .data_w_en(data_w_en), .data_r_en(data_r_en), .data_wmask(data_wmask),
        .data_addr(data_addr), .data_w(data_w),
        .data_r(data_r), .data_r_valid(data_r_valid), .data_w_ready(data_w_ready),
        .clint_timer_irq_o(clint_timer_irq_o), .timer_irq_ready_i(timer_irq_ready_i),
        .msip_o(msip_o)
    );

    ysyx_22050243_clint #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst),
        .data_w_en(data_w_en), .data_r_en(data_r_en), .data_wmask(data_wmask),
        .data_addr(data_addr), .data_w(data_w),
        .data_r(d4_data_r), .data_r_valid(d4_data_r_valid), .data_w_ready(d4_data_w_ready),
        .clint_timer_irq_o(d4_irq), .timer_irq_ready_i(timer_irq_ready_i),
        .msip_o(d4_msip)
    );

    typedef struct {
        logic        w;
        logic        r;
        logic [7:0]  mask;
        logic [63:0] addr;
        logic [63:0] wdat;
        logic [63:0] exp_r;
        logic        exp_msip;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request for exactly one sampling edge; returns #1 after that edge.
    task automatic req(input logic w, input logic r, input logic [7:0] m,
                       input logic [63:0] a, input logic [63:0] d);
        data_w_en  = w;
        data_r_en  = r;
        data_wmask = m;
        data_addr  = a;
        data_w     = d;
        @(posedge clk);
        #1;
        data_w_en  = 1'b0;
        data_r_en  = 1'b0;
        data_wmask = 8'h00;
    endtask

    task automatic ack();
        timer_irq_ready_i = 1'b1;
        @(posedge clk);
        #1;
        timer_irq_ready_i = 1'b0;
    endtask

    initial begin
        logic ok;
        logic seen;

        tbl[0]  = '{1, 0, 8'hFF, A_CMP,   64'h1122_3344_5566_7788, 64'h0, 0};
        tbl[1]  = '{1, 0, 8'h0F, A_CMP,   64'h0000_0000_AAAA_AAAA, 64'h0, 0};
        tbl[2]  = '{0, 1, 8'h00, A_CMP,   64'h0, 64'h1122_3344_AAAA_AAAA, 0};
        tbl[3]  = '{1, 0, 8'h00, A_CMP,   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0};
        tbl[4]  = '{0, 1, 8'h00, A_CMP,   64'h0, 64'h1122_3344_AAAA_AAAA, 0};
        tbl[5]  = '{1, 0, 8'hFF, A_MSIP,  64'h0000_0000_FFFF_FFFF, 64'h0, 1};
        tbl[6]  = '{0, 1, 8'h00, A_MSIP,  64'h0, 64'h1, 1};
        tbl[7]  = '{0, 1, 8'h00, A_UNMAP, 64'h0, 64'h0, 1};
        tbl[8]  = '{1, 0, 8'hFF, A_UNMAP, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
        tbl[9]  = '{0, 1, 8'h00, A_UNMAP, 64'h0, 64'h0, 1};
        tbl[10] = '{0, 1, 8'h00, A_CMP,   64'h0, 64'h1122_3344_AAAA_AAAA, 1};
        tbl[11] = '{1, 0, 8'h01, A_MSIP,  64'h0, 64'h0, 0};
        tbl[12] = '{0, 1, 8'h00, A_MSIP,  64'h0, 64'h0, 0};
        tbl[13] = '{1, 0, 8'hFE, A_MSIP,  64'h1, 64'h0, 0};
        tbl[14] = '{0, 1, 8'h00, A_MSIP,  64'h0, 64'h0, 0};
        tbl[15] = '{1, 1, 8'hFF, A_CMP,   64'h5, 64'h1122_3344_AAAA_AAAA, 0};
        tbl[16] = '{0, 1, 8'h00, A_CMP,   64'h0, 64'h5, 0};
        tbl[17] = '{1, 0, 8'h81, A_CMP,   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0};
        tbl[18] = '{0, 1, 8'h00, A_CMP,   64'h0, 64'hFF00_0000_0000_00FF, 0};

        rst = 1'b1;
        data_w_en = 1'b0; data_r_en = 1'b0; data_wmask = 8'h00;
        data_addr = '0; data_w = '0; timer_irq_ready_i = 1'b0;

        // Reset state.
        tick(3);
        chk("reset_outputs",
            {data_r, 4'(0), data_r_valid, data_w_ready, clint_timer_irq_o, msip_o}, '0);
        rst = 1'b0;
        chk("irq_low_at_release", {63'd0, clint_timer_irq_o}, 64'd0);
        tick(2);
        chk("irq_after_reset_compare", {63'd0, clint_timer_irq_o}, 64'd1);

        // Prescaler: 40 cycles at TICK_DIV=4 from a cleared mtime gives 10.
        req(1, 0, 8'hFF, A_TIME, 64'h0);
        tick(40);
        req(0, 1, 8'h00, A_TIME, 64'h0);
        chk("tick_div4_valid", {63'd0, d4_data_r_valid}, 64'd1);
        chk("tick_div4_mtime", d4_data_r, 64'd10);
        tick(1);
        chk("tick_div4_valid_drop", {63'd0, d4_data_r_valid}, 64'd0);

        // Register-map vector table.
        for (int i = 0; i < 19; i++) begin
            req(tbl[i].w, tbl[i].r, tbl[i].mask, tbl[i].addr, tbl[i].wdat);
            ok = (data_r_valid === tbl[i].r) && (data_w_ready === tbl[i].w) &&
                 (msip_o === tbl[i].exp_msip) && (!tbl[i].r || data_r === tbl[i].exp_r);
            nvec++;
            if (!ok) begin
                nfail++;
                $display("FAIL vec%0d: got rv=%0b wr=%0b msip=%0b r=0x%016h, expected rv=%0b wr=%0b msip=%0b r=0x%016h",
                         i, data_r_valid, data_w_ready, msip_o, data_r,
                         tbl[i].r, tbl[i].w, tbl[i].exp_msip, tbl[i].exp_r);
            end
        end

        // Wrap: the write beats the same-cycle increment; back-to-back reads each pulse.
        req(1, 0, 8'hFF, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE);
        req(0, 1, 8'h00, A_TIME, 64'h0);
        chk("wrap_write_overrides_tick", data_r, 64'hFFFF_FFFF_FFFF_FFFE);
        req(0, 1, 8'h00, A_TIME, 64'h0);
        chk("wrap_b2b_valid", {63'd0, data_r_valid}, 64'd1);
        chk("wrap_b2b_data", data_r, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1);
        chk("data_r_holds", data_r, 64'hFFFF_FFFF_FFFF_FFFF);
        req(0, 1, 8'h00, A_TIME, 64'h0);
        chk("wrap_to_one", data_r, 64'h1);

        // Interrupt handshake.
        req(1, 0, 8'hFF, A_TIME, 64'd0);
        req(1, 0, 8'hFF, A_CMP, 64'd20);
        ack();
        chk("irq_cleared_by_ack", {63'd0, clint_timer_irq_o}, 64'd0);
        tick(18);
        chk("irq_low_when_mtime_hits_cmp", {63'd0, clint_timer_irq_o}, 64'd0);
        tick(1);
        chk("irq_rises_next_cycle", {63'd0, clint_timer_irq_o}, 64'd1);
        ack();
        chk("irq_falls_after_ack", {63'd0, clint_timer_irq_o}, 64'd0);
        tick(5);
        chk("irq_stays_low_while_ge", {63'd0, clint_timer_irq_o}, 64'd0);
        req(1, 0, 8'hFF, A_CMP, 64'd100);
        req(1, 0, 8'hFF, A_CMP, 64'd30);
        chk("irq_low_after_rearm", {63'd0, clint_timer_irq_o}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1);
            seen = clint_timer_irq_o;
        end
        chk("irq_refires", {63'd0, seen}, 64'd1);
        req(1, 0, 8'hFF, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(2);
        chk("irq_held_after_cmp_raise", {63'd0, clint_timer_irq_o}, 64'd1);
        ack();
        chk("irq_held_cleared_by_ack", {63'd0, clint_timer_irq_o}, 64'd0);

        // Reset asserted together with a read: no response, everything cleared.
        req(1, 0, 8'hFF, A_MSIP, 64'h1);
        data_r_en = 1'b1;
        data_addr = A_CMP;
        rst = 1'b1;
        #1;
        chk("async_reset_clears", {data_r, 4'(0), data_w_ready, msip_o}, '0);
        @(posedge clk);
        #1;
        data_r_en = 1'b0;
        chk("no_valid_under_reset", {63'd0, data_r_valid}, 64'd0);
        tick(1);
        rst = 1'b0;
        chk("reset_outputs_mid_op",
            {data_r, 4'(0), data_r_valid, data_w_ready, clint_timer_irq_o, msip_o}, '0);
        tick(2);
        chk("irq_after_mid_op_reset", {63'd0, clint_timer_irq_o}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
